// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered RV32I integer execute stage.
// Decodes OP / OP-IMM / LUI / AUIPC, evaluates them through a combinational
// ALU and presents the result in a single-entry valid/ready output register.

package alu_exec_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
endpackage

// Combinational integer ALU; shift amount is the low log2(WIDTH) bits of b.
module alu
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    // Result mux over all supported operations.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: y = WIDTH'(a < b);
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = WIDTH'($signed(a) >>> shamt);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end
endmodule

module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd_addr,
    output logic [WIDTH-1:0] out_rd_val,
    output logic             out_wen,
    output logic             out_illegal,
    output logic [31:0]      retire_count
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_u;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    // Sign-extending casts keep the immediates correct for any WIDTH >= 32.
    assign imm_i  = WIDTH'($signed(in_instr[31:20]));
    assign imm_u  = WIDTH'($signed({in_instr[31:12], 12'b0}));

    // rs1 index is resolved upstream; only its value arrives here.
    logic unused_rs1_field;
    assign unused_rs1_field = ^in_instr[19:15];

    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    alu_op_e          alu_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             legal;
    logic [WIDTH-1:0] alu_y;

    // Decode: legality, ALU operation and operand selection.
    always_comb begin
        alu_op = ALU_ADD;
        op_a   = '0;
        op_b   = '0;
        legal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                op_a   = in_rs1_val;
                op_b   = in_rs2_val;
                alu_op = f3_to_op(funct3, funct7 == F7_ALT);
                legal  = (funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                op_a = in_rs1_val;
                op_b = imm_i;
                // Only SRAI uses the alternate encoding; ADDI has no subtract form.
                alu_op = f3_to_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                case (funct3)
                    3'b001:  legal = (funct7 == F7_BASE);
                    3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                op_b  = imm_u;
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                op_a  = in_pc;
                op_b  = imm_u;
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .op (alu_op),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );

    logic accept;
    logic drain;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // Output register: load on accept, empty on a drain with no new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_rd_addr <= '0;
            out_rd_val  <= '0;
            out_wen     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
            out_valid   <= 1'b1;
            out_rd_addr <= rd;
            out_rd_val  <= legal ? alu_y : '0;
            out_wen     <= legal && (rd != 5'd0);
            out_illegal <= !legal;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Retirement counter: one per output handshake, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (drain) begin
            retire_count <= retire_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vectors, backpressure,
// async reset mid-stall, counter wrap and randomized traffic against a
// scoreboard fed by an instruction-level reference model.
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_val;
    logic        out_wen;
    logic        out_illegal;
    logic [31:0] retire_count;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_rs1_val   (in_rs1_val),
        .in_rs2_val   (in_rs2_val),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd_addr  (out_rd_addr),
        .out_rd_val   (out_rd_val),
        .out_wen      (out_wen),
        .out_illegal  (out_illegal),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic        wen;
        logic        ill;
    } exp_t;

    // Reference model: what one instruction should retire as.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0]  f7 = ins[31:25];
        logic [2:0]  f3 = ins[14:12];
        logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] imm_u = {ins[31:12], 12'b0};
        logic        legal = 1'b0;
        logic [31:0] v = 32'd0;
        case (ins[6:0])
            7'b0110011: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                v = ref_op(f3, f7 == 7'h20, a, b);
            end
            7'b0010011: begin
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                 legal = 1'b1;
                v = ref_op(f3, f3 == 3'd5 && f7 == 7'h20, a, imm_i);
            end
            7'b0110111: begin legal = 1'b1; v = imm_u; end
            7'b0010111: begin legal = 1'b1; v = pc + imm_u; end
            default:    legal = 1'b0;
        endcase
        e.rd  = ins[11:7];
        e.val = legal ? v : 32'd0;
        e.wen = legal && (ins[11:7] != 5'd0);
        e.ill = !legal;
        return e;
    endfunction

    exp_t        exp_q[$];
    logic [31:0] model_retire = 32'd0;

    // Scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic ready_exp;
            ready_exp = (exp_q.size() == 0) || out_ready;
            check("in_ready", 32'(in_ready), 32'(ready_exp));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("retire_count", retire_count, model_retire);
            if (exp_q.size() != 0 && out_valid) begin
                check("rd_addr", 32'(out_rd_addr), 32'(exp_q[0].rd));
                check("rd_val", out_rd_val, exp_q[0].val);
                check("wen", 32'(out_wen), 32'(exp_q[0].wen));
                check("illegal", 32'(out_illegal), 32'(exp_q[0].ill));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    model_retire = model_retire + 32'd1;
                end
            end
            if (in_valid && ready_exp)
                exp_q.push_back(model(in_instr, in_pc, in_rs1_val, in_rs2_val));
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid   = 1'b1;
        in_instr   = ins;
        in_pc      = pc;
        in_rs1_val = a;
        in_rs2_val = b;
    endtask

    // One instruction with a free output; check the registered result by value.
    task automatic directed(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_val, input logic exp_wen, input logic exp_ill);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(ins, pc, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".val"}, out_rd_val, exp_val);
        check({tag, ".wen"}, 32'(out_wen), 32'(exp_wen));
        check({tag, ".ill"}, 32'(out_illegal), 32'(exp_ill));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] f7;
        logic [6:0] opc;
        int sel = $urandom_range(0, 9);
        int fs  = $urandom_range(0, 3);
        f7 = (fs < 2) ? 7'h00 : (fs == 2) ? 7'h20 : 7'($urandom);
        if (sel <= 3)      opc = 7'b0110011;
        else if (sel <= 6) opc = 7'b0010011;
        else if (sel == 7) opc = 7'b0110111;
        else if (sel == 8) opc = 7'b0010111;
        else               opc = 7'($urandom);
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.rd_val", out_rd_val, 32'd0);
        check("reset.retire", retire_count, 32'd0);
        rst_n = 1'b1;

        // Directed vectors.
        directed("addi", 32'hFFF00293, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("addi.rd", 32'(out_rd_addr), 32'd5);
        @(posedge clk); #1;
        check("addi.retire", retire_count, 32'd1);
        directed("sub", 32'h402081B3, 32'h0, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
        directed("srai", 32'h4040D093, 32'h0, 32'h80000000, 32'h0, 32'hF8000000, 1'b1, 1'b0);
        directed("lui", 32'h123453B7, 32'h0, 32'h0, 32'h0, 32'h12345000, 1'b1, 1'b0);
        directed("auipc", 32'h00001097, 32'h100, 32'h0, 32'h0, 32'h00001100, 1'b1, 1'b0);
        directed("ill_f7", 32'h40209133, 32'h0, 32'h3, 32'h4, 32'h0, 1'b0, 1'b1);
        directed("ill_opc", 32'h00002083, 32'h0, 32'h3, 32'h4, 32'h0, 1'b0, 1'b1);
        directed("x0", 32'h00500013, 32'h0, 32'h0, 32'h0, 32'h5, 1'b0, 1'b0);

        // Backpressure: first result must hold while the next instruction waits.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(32'h12300313, 32'h0, 32'h0, 32'h0);   // ADDI x6,x0,0x123
        @(posedge clk); #1;
        drive(32'h00734433, 32'h0, 32'h0F0F0F0F, 32'hFF00FF00); // XOR x8,x6,x7
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check("bp.val", out_rd_val, 32'h00000123);
            check("bp.retire", retire_count, model_retire);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 4) != 0)
                drive(rand_instr(), $urandom, $urandom, $urandom);
            else
                in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain.empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a result is stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(32'hFFF00293, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stall.valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_retire = 32'd0;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        check("arst.rd_addr", 32'(out_rd_addr), 32'd0);
        check("arst.rd_val", out_rd_val, 32'd0);
        check("arst.wen", 32'(out_wen), 32'd0);
        check("arst.illegal", 32'(out_illegal), 32'd0);
        check("arst.retire", retire_count, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Counter wrap from all-ones.
        @(posedge clk); #2;
        force dut.retire_count = 32'hFFFFFFFF;
        #1;
        release dut.retire_count;
        model_retire = 32'hFFFFFFFF;
        directed("wrap", 32'h00100093, 32'h0, 32'h0, 32'h0, 32'h1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("wrap.retire", retire_count, 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
